// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and NOP control constant for pipeline stage registers
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;
  localparam bit PIPE_CTRL_NOP = 1'b0;
endpackage

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg: data+ctrl entry register with load and independent ctrl/data clears
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr_ctrl,
  input  logic              clr_data,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic [DATA_W-1:0] q_data,
  output logic [CTRL_W-1:0] q_ctrl
);
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  always_comb begin
    data_d = clr_data ? '0 : load ? d_data : data_q;
    ctrl_d = clr_ctrl ? {CTRL_W{PIPE_CTRL_NOP}} : load ? d_ctrl : ctrl_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      ctrl_q <= {CTRL_W{PIPE_CTRL_NOP}};
    end else begin
      data_q <= data_d;
      ctrl_q <= ctrl_d;
    end
  end
  assign q_data = data_q;
  assign q_ctrl = ctrl_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage with optional skid slot, stall/flush/bubble and status
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int CTRL_W        = 16,
  parameter bit SKID          = 1'b1,
  parameter bit ZERO_ON_FLUSH = 1'b1,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              bubble,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        count,
  output logic [CNT_W-1:0]  bubble_cnt
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic cap, push, bpush, any_push, pop, main_ld, skid_ld;
  logic [DATA_W-1:0] skid_data, ins_data, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl, ins_ctrl, main_ctrl_d;
  assign cap       = SKID ? (state_q != TWO) : (state_q == EMPTY || out_ready);
  assign in_ready  = !rst && !stall && !bubble && cap;
  assign out_valid = !stall && state_q != EMPTY;
  assign push      = in_valid && in_ready;
  assign bpush     = bubble && !stall && !rst && cap;
  assign any_push  = push || bpush;
  assign pop       = out_valid && out_ready;
  assign ins_data  = bpush ? '0 : in_data;
  assign ins_ctrl  = bpush ? {CTRL_W{PIPE_CTRL_NOP}} : in_ctrl;
  assign main_data_d = state_q == TWO ? skid_data : ins_data;
  assign main_ctrl_d = state_q == TWO ? skid_ctrl : ins_ctrl;
  always_comb begin
    state_d = state_q;
    main_ld = 1'b0;
    skid_ld = 1'b0;
    case (state_q)
      EMPTY: begin
        main_ld = any_push;
        state_d = any_push ? ONE : EMPTY;
      end
      ONE: begin
        main_ld = any_push && pop;
        skid_ld = any_push && !pop;
        state_d = any_push ? (pop ? ONE : TWO) : (pop ? EMPTY : ONE);
      end
      TWO: begin
        main_ld = pop;
        state_d = pop ? ONE : TWO;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
      main_ld = 1'b0;
      skid_ld = 1'b0;
    end
    bcnt_d = (bpush && bcnt_q != '1) ? bcnt_q + CNT_W'(1) : bcnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end
  pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk(clk), .rst(rst), .load(main_ld), .clr_ctrl(flush), .clr_data(flush && ZERO_ON_FLUSH),
    .d_data(main_data_d), .d_ctrl(main_ctrl_d), .q_data(out_data), .q_ctrl(out_ctrl)
  );
  if (SKID) begin : g_skid
    pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
      .clk(clk), .rst(rst), .load(skid_ld), .clr_ctrl(flush), .clr_data(flush && ZERO_ON_FLUSH),
      .d_data(ins_data), .d_ctrl(ins_ctrl), .q_data(skid_data), .q_ctrl(skid_ctrl)
    );
  end else begin : g_no_skid
    assign skid_data = '0;
    assign skid_ctrl = '0;
  end
  assign count      = state_q;
  assign bubble_cnt = bcnt_q;
endmodule
